// File: rtl/signadd_pipe_pkg.sv
// Shared encodings and width-dependent saturation limits for the pipelined signed adder.
package signadd_pipe_pkg;

   localparam int INFMT_TC = 0;
   localparam int INFMT_SM = 1;

   localparam int SAT_MAXW = 64;

   // Saturation limits are built for widths up to SAT_MAXW and sliced at the use site.
   function automatic logic [SAT_MAXW-1:0] sat_max(input int w);
      logic [SAT_MAXW-1:0] r;
      r = '0;
      for (int i = 0; i < SAT_MAXW; i++) begin
         if (i < w - 1) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [SAT_MAXW-1:0] sat_min(input int w);
      logic [SAT_MAXW-1:0] r;
      r = '0;
      for (int i = 0; i < SAT_MAXW; i++) begin
         if (i == w - 1) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/signadd_pipe_if.sv
// Operand/result handshake bundle between producers, the adder pipe and its consumer.
interface signadd_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, sat, out_ready,
      input  in_ready, out_valid, sum, carry, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, sat, out_ready,
      output in_ready, out_valid, sum, carry, ovf
   );
endinterface

// File: rtl/signadd_seg.sv
// Combinational ripple-carry slice; one per pipeline segment.
module signadd_seg #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         c_i,
   output logic [W-1:0] s_o,
   output logic         c_o
);
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
endmodule

// File: rtl/signadd_pipe.sv
// Pipelined signed add/subtract: SEGS ripple segments, one register per segment, valid/ready
// handshake with whole-pipe stall, optional sign-magnitude inputs and saturation.
module signadd_pipe
   import signadd_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEGS  = 2,
   parameter int INFMT = INFMT_TC
) (
   input  logic           clk1,
   input  logic           rst,
   signadd_pipe_if.slave  bus
);
   localparam int SW = WIDTH / SEGS;
   localparam int L  = SEGS - 1;

   localparam logic [SAT_MAXW-1:0] SAT_MAX_FULL = sat_max(WIDTH);
   localparam logic [SAT_MAXW-1:0] SAT_MIN_FULL = sat_min(WIDTH);
   localparam logic [WIDTH-1:0]    SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]    SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

   // Negative zero falls out naturally: -0 == 0.
   function automatic logic signed [WIDTH-1:0] to_tc(input logic [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] mag;
      mag = {1'b0, x[WIDTH-2:0]};
      if (INFMT == INFMT_SM) return x[WIDTH-1] ? -mag : mag;
      return $signed(x);
   endfunction

   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                 input logic             a_neg,
                                                 input logic             sat_en,
                                                 input logic             ov);
      if (sat_en && ov) return a_neg ? SAT_MIN : SAT_MAX;
      return raw;
   endfunction

   logic                    stall;
   logic                    en;
   logic signed [WIDTH-1:0] a_tc;
   logic signed [WIDTH-1:0] b_tc;
   logic        [WIDTH-1:0] b_eff;

   assign stall        = bus.out_valid && !bus.out_ready;
   assign en           = !stall;
   assign bus.in_ready = en;

   assign a_tc  = to_tc(bus.a);
   assign b_tc  = to_tc(bus.b);
   assign b_eff = bus.sub ? ~b_tc : b_tc;

   for (genvar k = 0; k < SEGS; k++) begin : g_stg
      // Stage k: add slice k; carry the not-yet-added operand bits and finished result bits forward.
      localparam int LO  = k * SW;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]        a_src;
      logic [REM-1:0]        b_src;
      logic                  cin_src;
      logic                  sat_src;
      logic                  vld_src;
      logic [SW-1:0]         s_seg;
      logic                  c_seg;
      logic [(k+1)*SW-1:0]   res_d;
      logic                  vld_q;
      logic                  cy_q;

      if (k == 0) begin : g_src
         assign a_src   = a_tc;
         assign b_src   = b_eff;
         assign cin_src = bus.sub;
         assign sat_src = bus.sat;
         assign vld_src = bus.in_valid;
         assign res_d   = s_seg;
      end else begin : g_src
         assign a_src   = g_stg[k-1].g_hold.a_hi_q;
         assign b_src   = g_stg[k-1].g_hold.b_hi_q;
         assign cin_src = g_stg[k-1].cy_q;
         assign sat_src = g_stg[k-1].g_hold.sat_q;
         assign vld_src = g_stg[k-1].vld_q;
         assign res_d   = {s_seg, g_stg[k-1].g_hold.res_q};
      end

      signadd_seg #(.W(SW)) u_seg (
         .a_i (a_src[SW-1:0]),
         .b_i (b_src[SW-1:0]),
         .c_i (cin_src),
         .s_o (s_seg),
         .c_o (c_seg)
      );

      always_ff @(posedge clk1) begin
         if (rst)     vld_q <= 1'b0;
         else if (en) vld_q <= vld_src;
      end

      always_ff @(posedge clk1) begin
         if (en) cy_q <= c_seg;
      end

      if (k < L) begin : g_hold
         logic [REM-SW-1:0]   a_hi_q;
         logic [REM-SW-1:0]   b_hi_q;
         logic [(k+1)*SW-1:0] res_q;
         logic                sat_q;

         always_ff @(posedge clk1) begin
            if (en) begin
               a_hi_q <= a_src[REM-1:SW];
               b_hi_q <= b_src[REM-1:SW];
               res_q  <= res_d;
               sat_q  <= sat_src;
            end
         end
      end else begin : g_last
         // Last slice holds both operand MSBs, so overflow and saturation resolve here.
         logic             ovf_d;
         logic [WIDTH-1:0] sum_q;
         logic             ovf_q;

         assign ovf_d = (a_src[SW-1] == b_src[SW-1]) && (s_seg[SW-1] != a_src[SW-1]);

         always_ff @(posedge clk1) begin
            if (en) begin
               sum_q <= saturate(res_d, a_src[SW-1], sat_src, ovf_d);
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign bus.out_valid = g_stg[L].vld_q;
   assign bus.sum       = bus.out_valid ? g_stg[L].g_last.sum_q : '0;
   assign bus.carry     = bus.out_valid & g_stg[L].cy_q;
   assign bus.ovf       = bus.out_valid & g_stg[L].g_last.ovf_q;

endmodule

// File: tb/tb_signadd_pipe.sv
// Bench for signadd_pipe: directed scenarios plus randomized traffic against an arithmetic model.
module tb_signadd_pipe;
   localparam int WIDTH = 8;
   localparam int SEGS  = 2;

   logic clk1 = 1'b0;
   logic rst;
   always #5 clk1 = ~clk1;

   signadd_pipe_if #(.WIDTH(WIDTH)) if_tc ();
   signadd_pipe_if #(.WIDTH(WIDTH)) if_sm ();

   signadd_pipe #(.WIDTH(WIDTH), .SEGS(SEGS), .INFMT(0)) u_tc (.clk1(clk1), .rst(rst), .bus(if_tc));
   signadd_pipe #(.WIDTH(WIDTH), .SEGS(SEGS), .INFMT(1)) u_sm (.clk1(clk1), .rst(rst), .bus(if_sm));

   // index 0 = two's-complement DUT, index 1 = sign-magnitude DUT
   logic             iv [2];
   logic             ordy [2];
   logic             subv [2];
   logic             satv [2];
   logic [WIDTH-1:0] av [2];
   logic [WIDTH-1:0] bv [2];
   logic             ir [2];
   logic             ov [2];
   logic             cyo [2];
   logic             ovo [2];
   logic [WIDTH-1:0] so [2];

   assign if_tc.in_valid = iv[0];   assign if_sm.in_valid = iv[1];
   assign if_tc.out_ready = ordy[0]; assign if_sm.out_ready = ordy[1];
   assign if_tc.sub = subv[0];      assign if_sm.sub = subv[1];
   assign if_tc.sat = satv[0];      assign if_sm.sat = satv[1];
   assign if_tc.a = av[0];          assign if_sm.a = av[1];
   assign if_tc.b = bv[0];          assign if_sm.b = bv[1];
   assign ir[0] = if_tc.in_ready;   assign ir[1] = if_sm.in_ready;
   assign ov[0] = if_tc.out_valid;  assign ov[1] = if_sm.out_valid;
   assign cyo[0] = if_tc.carry;     assign cyo[1] = if_sm.carry;
   assign ovo[0] = if_tc.ovf;       assign ovo[1] = if_sm.ovf;
   assign so[0] = if_tc.sum;        assign so[1] = if_sm.sum;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
   } res_t;

   function automatic int value_of(input logic [7:0] x, input bit sm);
      if (sm) return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
      return int'($signed(x));
   endfunction

   // Exact integer arithmetic; overflow means the true result leaves the 8-bit signed range.
   function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                  input bit sub, input bit sat, input bit sm);
      int   va, vb, t, ua, ub;
      res_t r;
      va = value_of(a, sm);
      vb = value_of(b, sm);
      t  = sub ? va - vb : va + vb;
      ua = va & 255;
      ub = vb & 255;
      r.carry = sub ? (ua >= ub) : (ua + ub > 255);
      r.ovf   = (t > 127) || (t < -128);
      if (sat && r.ovf) r.sum = (t > 0) ? 8'h7F : 8'h80;
      else              r.sum = t[7:0];
      return r;
   endfunction

   task automatic send_one(input int d, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic sat,
                           output res_t obs, output logic early_v, output logic late_v);
      @(negedge clk1);
      iv[d] = 1'b1; av[d] = a; bv[d] = b; subv[d] = sub; satv[d] = sat; ordy[d] = 1'b1;
      @(posedge clk1);
      @(negedge clk1);
      iv[d] = 1'b0;
      early_v = ov[d];
      @(posedge clk1);
      @(negedge clk1);
      late_v = ov[d];
      obs = '{so[d], cyo[d], ovo[d]};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b1; av[d] = 8'h11; bv[d] = 8'h22; subv[d] = 1'b0; satv[d] = 1'b0; ordy[d] = 1'b1;
      end
      repeat (2) @(posedge clk1);
      @(negedge clk1);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if ({ov[d], so[d], cyo[d], ovo[d]} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got v=%b s=%h c=%b o=%b, need all 0", d, ov[d], so[d], cyo[d], ovo[d]);
         end
      end
      rst = 1'b0;
      iv[0] = 1'b0; iv[1] = 1'b0;
      @(negedge clk1);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (ir[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready dut%0d: got %b, need 1", d, ir[d]);
         end
      end
      repeat (4) begin
         @(negedge clk1);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ov[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_no_beat dut%0d: out_valid got %b, need 0", d, ov[d]);
            end
         end
      end
   endtask

   task automatic test_add_ovf();
      res_t r; logic ev, lv;
      send_one(0, 8'h64, 8'h1E, 1'b0, 1'b0, r, ev, lv);
      n_checks++;
      if (ev !== 1'b0 || lv !== 1'b1) begin
         n_fail++; $display("FAIL add_latency: valid at +1=%b +2=%b, need 0 then 1", ev, lv);
      end
      n_checks++;
      if (r !== {8'h82, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL add_ovf: got sum=%h c=%b o=%b, need 82 0 1", r.sum, r.carry, r.ovf);
      end
      send_one(0, 8'h64, 8'h1E, 1'b0, 1'b1, r, ev, lv);
      n_checks++;
      if (lv !== 1'b1 || r !== {8'h7F, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL add_sat: got v=%b sum=%h c=%b o=%b, need 1 7f 0 1", lv, r.sum, r.carry, r.ovf);
      end
   endtask

   task automatic test_sub();
      res_t r; logic ev, lv;
      send_one(0, 8'h05, 8'h07, 1'b1, 1'b0, r, ev, lv);
      n_checks++;
      if (lv !== 1'b1 || r !== {8'hFE, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL sub_neg: got v=%b sum=%h c=%b o=%b, need 1 fe 0 0", lv, r.sum, r.carry, r.ovf);
      end
      send_one(0, 8'h80, 8'h01, 1'b1, 1'b0, r, ev, lv);
      n_checks++;
      if (lv !== 1'b1 || r !== {8'h7F, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL sub_ovf: got v=%b sum=%h c=%b o=%b, need 1 7f 1 1", lv, r.sum, r.carry, r.ovf);
      end
      send_one(0, 8'h80, 8'h01, 1'b1, 1'b1, r, ev, lv);
      n_checks++;
      if (lv !== 1'b1 || r !== {8'h80, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL sub_sat: got v=%b sum=%h c=%b o=%b, need 1 80 1 1", lv, r.sum, r.carry, r.ovf);
      end
   endtask

   task automatic test_sign_mag();
      res_t r; logic ev, lv;
      send_one(1, 8'h85, 8'h03, 1'b0, 1'b0, r, ev, lv);
      n_checks++;
      if (lv !== 1'b1 || r !== {8'hFE, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL sm_add: got v=%b sum=%h c=%b o=%b, need 1 fe 0 0", lv, r.sum, r.carry, r.ovf);
      end
      send_one(1, 8'h80, 8'h00, 1'b0, 1'b0, r, ev, lv);
      n_checks++;
      if (lv !== 1'b1 || r !== {8'h00, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL sm_negzero: got v=%b sum=%h c=%b o=%b, need 1 00 0 0", lv, r.sum, r.carry, r.ovf);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_sums [4];
      int sent = 0, got = 0, stall_left = 0, cyc = 0;
      bit first_seen = 0;
      exp_sums[0] = 8'h02; exp_sums[1] = 8'h04; exp_sums[2] = 8'h06; exp_sums[3] = 8'h08;
      subv[0] = 1'b0; satv[0] = 1'b0;
      while (got < 4 && cyc < 40) begin
         @(negedge clk1);
         cyc++;
         if (ov[0] && !first_seen) begin first_seen = 1; stall_left = 3; end
         iv[0] = (sent < 4);
         av[0] = 8'(sent + 1);
         bv[0] = 8'(sent + 1);
         if (stall_left > 0) begin
            ordy[0] = 1'b0;
            #1;
            n_checks++;
            if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || so[0] !== 8'h02) begin
               n_fail++;
               $display("FAIL bp_stall: got in_ready=%b v=%b sum=%h, need 0 1 02", ir[0], ov[0], so[0]);
            end
            stall_left--;
         end else begin
            ordy[0] = 1'b1;
            #1;
         end
         if (ov[0] && ordy[0]) begin
            n_checks++;
            if (so[0] !== exp_sums[got]) begin
               n_fail++; $display("FAIL bp_order beat%0d: got %h, need %h", got, so[0], exp_sums[got]);
            end
            got++;
         end
         if (iv[0] && ir[0]) sent++;
      end
      iv[0] = 1'b0;
      n_checks++;
      if (got != 4) begin
         n_fail++; $display("FAIL bp_count: got %0d results, need 4", got);
      end
   endtask

   task automatic test_reset_mid();
      res_t r; logic ev, lv;
      int delivered = 0;
      subv[0] = 1'b0; satv[0] = 1'b0; ordy[0] = 1'b0;
      @(negedge clk1); iv[0] = 1'b1; av[0] = 8'h10; bv[0] = 8'h20;
      @(negedge clk1); av[0] = 8'h30; bv[0] = 8'h40;
      if (ov[0] && ordy[0]) delivered++;
      @(negedge clk1); iv[0] = 1'b0; rst = 1'b1;
      if (ov[0] && ordy[0]) delivered++;
      @(negedge clk1); rst = 1'b0; ordy[0] = 1'b1;
      repeat (3) begin
         n_checks++;
         if ({ov[0], so[0], cyo[0], ovo[0]} !== 11'b0) begin
            n_fail++; $display("FAIL rstmid_idle: got v=%b s=%h c=%b o=%b, need all 0", ov[0], so[0], cyo[0], ovo[0]);
         end
         @(negedge clk1);
      end
      n_checks++;
      if (delivered != 0) begin
         n_fail++; $display("FAIL rstmid_delivered: got %0d, need 0", delivered);
      end
      send_one(0, 8'h07, 8'h09, 1'b0, 1'b0, r, ev, lv);
      n_checks++;
      if (ev !== 1'b0 || lv !== 1'b1 || r !== {8'h10, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rstmid_new: got +1=%b +2=%b sum=%h c=%b o=%b, need 0 1 10 0 0", ev, lv, r.sum, r.carry, r.ovf);
      end
      repeat (2) begin
         @(negedge clk1);
         n_checks++;
         if (ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_extra: out_valid got %b, need 0", ov[0]);
         end
      end
   endtask

   function automatic logic [7:0] pick_operand();
      logic [7:0] edges [5];
      edges[0] = 8'h00; edges[1] = 8'h7F; edges[2] = 8'h80; edges[3] = 8'hFF; edges[4] = 8'h01;
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return 8'($urandom);
   endfunction

   task automatic test_random();
      res_t exp_mem [2][64];
      int   wr [2], rd [2];
      bit   stalled_prev [2];
      res_t prev_out [2];
      res_t e;
      int   cyc = 0;
      for (int d = 0; d < 2; d++) begin wr[d] = 0; rd[d] = 0; stalled_prev[d] = 0; prev_out[d] = '0; end
      while (cyc < 600 && (cyc < 300 || wr[0] != rd[0] || wr[1] != rd[1])) begin
         @(negedge clk1);
         for (int d = 0; d < 2; d++) begin
            if (stalled_prev[d]) begin
               n_checks++;
               if (ov[d] !== 1'b1 || {so[d], cyo[d], ovo[d]} !== prev_out[d]) begin
                  n_fail++;
                  $display("FAIL rnd_hold dut%0d: got v=%b %h, need 1 %h", d, ov[d], {so[d], cyo[d], ovo[d]}, prev_out[d]);
               end
            end
            if (!ov[d]) begin
               n_checks++;
               if ({so[d], cyo[d], ovo[d]} !== 10'b0) begin
                  n_fail++; $display("FAIL rnd_gate dut%0d: got %h, need 0", d, {so[d], cyo[d], ovo[d]});
               end
            end
            ordy[d] = ($urandom_range(0, 3) != 0);
            iv[d]   = (cyc < 300) && ($urandom_range(0, 2) != 0);
            av[d]   = pick_operand();
            bv[d]   = pick_operand();
            subv[d] = 1'($urandom_range(0, 1));
            satv[d] = 1'($urandom_range(0, 1));
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            if (ov[d] && ordy[d]) begin
               n_checks++;
               if (rd[d] == wr[d]) begin
                  n_fail++; $display("FAIL rnd_unexpected dut%0d: got %h, need no beat", d, so[d]);
               end else begin
                  e = exp_mem[d][rd[d] % 64];
                  if ({so[d], cyo[d], ovo[d]} !== e) begin
                     n_fail++;
                     $display("FAIL rnd_result dut%0d: got sum=%h c=%b o=%b, need sum=%h c=%b o=%b",
                              d, so[d], cyo[d], ovo[d], e.sum, e.carry, e.ovf);
                  end
                  rd[d]++;
               end
            end
            if (iv[d] && ir[d]) begin
               exp_mem[d][wr[d] % 64] = model(av[d], bv[d], subv[d], satv[d], d == 1);
               wr[d]++;
            end
            stalled_prev[d] = ov[d] && !ordy[d];
            prev_out[d]     = '{so[d], cyo[d], ovo[d]};
         end
         cyc++;
      end
      iv[0] = 1'b0; iv[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (wr[d] != rd[d] || wr[d] == 0) begin
            n_fail++; $display("FAIL rnd_drain dut%0d: sent %0d received %0d", d, wr[d], rd[d]);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1; subv[d] = 1'b0; satv[d] = 1'b0; av[d] = '0; bv[d] = '0;
      end
      rst = 1'b1;
      test_reset();
      test_add_ovf();
      test_sub();
      test_sign_mag();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/signadd_pipe.md
Name: signadd_pipe

Overview:
- Next-generation signed adder: pipelined, parametrised-width add/subtract with a valid/ready handshake.
- Carry chain is split into SEGS ripple segments with one register per segment boundary, so throughput is one operation per clock.
- Adds run-time subtract and saturate modes, signed-overflow detection and optional sign-magnitude input conversion.
- Sits between operand producers and downstream accumulators; replaces the single-stage signed adder in new datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- SEGS, 2, number of pipeline segments; WIDTH % SEGS == 0; latency = SEGS cycles.
- INFMT, 0, input format: 0 = two's complement, 1 = sign-magnitude (MSB sign, rest magnitude).

Ports:
- clk1  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, format per INFMT.
- b  in  WIDTH  operand B, format per INFMT.
- sub  in  1  1 = A-B, 0 = A+B; sampled with the beat.
- sat  in  1  1 = saturate on overflow; sampled with the beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  two's-complement result.
- carry  out  1  raw carry out of the MSB.
- ovf  out  1  signed overflow of the unsaturated result.

Behaviour:
- Reset (rst=1 at a clk1 edge): all stage valid bits cleared; out_valid=0, sum=0, carry=0, ovf=0. in_ready=1 from the first cycle after reset. In-flight beats are dropped; a beat presented while rst=1 is not accepted.
- Accept: a beat is accepted when in_valid && in_ready. sub and sat travel with the beat.
- Latency: the result appears on out_valid exactly SEGS cycles after acceptance when no stall occurs.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. On stall the entire pipeline holds and the output beat stays stable. There is no bubble collapse. Order is preserved and no beat is lost or duplicated.
- Input conversion (INFMT=1), done in stage 0:
  - Magnitude m with sign s maps to m if s=0, else -m.
  - Negative zero (sign 1, magnitude 0) maps to 0.
- Arithmetic:
  - B' = sub ? ~B : B, with carry-in = sub.
  - Segment k adds bits [k*W/SEGS +: W/SEGS] using the registered carry from segment k-1.
  - Upper operand bits are delay-skewed and lower result bits deskewed so that all bits of a beat emerge together.
- carry: carry out of bit WIDTH-1 of A + B' + cin; not affected by sat.
- ovf = (A[MSB] == B'[MSB]) && (raw_sum[MSB] != A[MSB]).
- Saturation: when sat=1 and ovf=1, sum = max positive (0111…1) if A[MSB]=0, else min negative (1000…0). ovf still reads 1.
- Output gating: sum, carry and ovf are forced to 0 whenever out_valid=0.
- Simultaneous events: rst has priority over accept and over stall. Accept and output drain in the same cycle is legal.

Decomposition:
- Shared package: format encodings (INFMT_TC=0, INFMT_SM=1) and constant functions for SAT_MAX/SAT_MIN by width.
- One sub-module, signadd_seg: a combinational WIDTH/SEGS ripple adder slice with carry in/out.
- The top level instantiates SEGS slices via generate and owns the pipeline registers, skew/deskew, handshake, conversion, overflow and saturation logic.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, carry=0, ovf=0, no beat emitted later; in_ready=1 after reset.
- Add overflow (WIDTH=8, SEGS=2, INFMT=0):
  - a=0x64, b=0x1E, sub=0, sat=0 -> after 2 cycles sum=0x82, ovf=1, carry=0.
  - Same operands with sat=1 -> sum=0x7F, ovf=1.
- Subtract:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1, carry=1.
  - Same with sat=1 -> sum=0x80.
- Sign-magnitude (INFMT=1):
  - a=0x85, b=0x03, sub=0 -> sum=0xFE.
  - a=0x80, b=0x00 -> sum=0x00, ovf=0.
- Backpressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4), out_ready low for 3 cycles when the first result appears -> in_ready low during the stall, result 0x02 held stable, then 0x02, 0x04, 0x06, 0x08 in order, none lost.
- Reset mid-operation: accept 2 beats, assert rst 1 cycle after the second accept -> neither result ever appears; out_valid=0 with outputs 0 until a new beat arrives SEGS cycles later.
